// File: rtl/ag_stack_seq_if.sv
// Request/beat bundle between the decode/AG latches, the stack sequencer and ME.
// START_V/START_RDY: a request transfers on a cycle where both are high and FLUSH is low;
// ADDR_V has no ready of its own, STALL_IN from ME holds the presented beat instead.
interface ag_stack_seq_if #(
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 8
);
    localparam int NB_W  = $clog2(MAX_BEATS + 1);
    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic              START_V;
    logic              START_RDY;
    logic              DIR_POP;
    logic [1:0]        DATA_SIZE;
    logic [NB_W-1:0]   NUM_BEATS;
    logic [ADDR_W-1:0] SP_IN;
    logic [15:0]       SEG_BASE;
    logic [ADDR_W-1:0] SEG_LIMIT;
    logic              FLUSH;
    logic              STALL_IN;
    logic              ADDR_V;
    logic [ADDR_W-1:0] ADDR_OUT;
    logic [IDX_W-1:0]  BEAT_IDX;
    logic              LAST;
    logic              DONE;
    logic [ADDR_W-1:0] FINAL_SP;
    logic              SEG_LIMIT_EXC_OUT;
    logic [1:0]        dbg_state;

    modport master (
        output START_V, DIR_POP, DATA_SIZE, NUM_BEATS, SP_IN, SEG_BASE, SEG_LIMIT,
               FLUSH, STALL_IN,
        input  START_RDY, ADDR_V, ADDR_OUT, BEAT_IDX, LAST, DONE, FINAL_SP,
               SEG_LIMIT_EXC_OUT, dbg_state
    );

    modport slave (
        input  START_V, DIR_POP, DATA_SIZE, NUM_BEATS, SP_IN, SEG_BASE, SEG_LIMIT,
               FLUSH, STALL_IN,
        output START_RDY, ADDR_V, ADDR_OUT, BEAT_IDX, LAST, DONE, FINAL_SP,
               SEG_LIMIT_EXC_OUT, dbg_state
    );
endinterface

// File: rtl/ag_stack_seq.sv
// Multi-beat stack address sequencer: one segmented linear address per beat plus final SP.
// Define AG_SEQ_LIMIT_CHECK_EN to check every beat against the SS limit before presenting it.
module ag_stack_seq #(
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 8,
    parameter int SEG_SHIFT = 16
) (
    input logic           CLK,
    input logic           RST,
    ag_stack_seq_if.slave bus
);
    localparam int NB_W  = $clog2(MAX_BEATS + 1);
    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [NB_W-1:0] MAX_N = NB_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic              wrap_q, wrap_d;
    logic [3:0]        size_q, size_d;
    logic              dir_pop_q, dir_pop_d;
    logic [NB_W-1:0]   n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [ADDR_W-1:0] final_sp_q, final_sp_d;
    logic              addr_v_q, addr_v_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;

    function automatic logic [3:0] size_bytes(input logic [1:0] ds);
        case (ds)
            2'b10:   return 4'd4;
            2'b11:   return 4'd8;
            default: return 4'd2;
        endcase
    endfunction

    logic              accept;
    logic [3:0]        req_size;
    logic [NB_W-1:0]   req_n;
    logic [ADDR_W-1:0] req_base;
    logic [AW1-1:0]    first_off_w;
    logic [AW1-1:0]    next_off_w;
    logic [IDX_W-1:0]  idx_inc;
    logic              first_viol;
    logic              next_viol;

    assign accept   = (state_q == IDLE) && rdy_q && bus.START_V && !bus.FLUSH;
    assign req_size = size_bytes(bus.DATA_SIZE);
    assign req_n    = (bus.NUM_BEATS > MAX_N) ? MAX_N : bus.NUM_BEATS;
    assign req_base = ADDR_W'({{ADDR_W{1'b0}}, bus.SEG_BASE} << SEG_SHIFT);
    assign idx_inc  = idx_q + IDX_W'(1);

    // Offsets carry one extra bit so a wrap past 0 or 2^ADDR_W stays visible to the limit check.
    assign first_off_w = bus.DIR_POP ? {1'b0, bus.SP_IN}
                                     : {1'b0, bus.SP_IN} - AW1'(req_size);
    assign next_off_w  = dir_pop_q ? {1'b0, offset_q} + AW1'(size_q)
                                   : {1'b0, offset_q} - AW1'(size_q);

`ifdef AG_SEQ_LIMIT_CHECK_EN
    logic [ADDR_W-1:0] limit_q;

    function automatic logic over_limit(input logic [AW1-1:0]    off_w,
                                        input logic              wrapped,
                                        input logic [3:0]        sz,
                                        input logic [ADDR_W-1:0] lim);
        logic [AW1-1:0] end_w;
        end_w = {1'b0, off_w[ADDR_W-1:0]} + AW1'(sz) - AW1'(1);
        return wrapped | off_w[ADDR_W] | (end_w > {1'b0, lim});
    endfunction

    assign first_viol = over_limit(first_off_w, 1'b0, req_size, bus.SEG_LIMIT);
    assign next_viol  = over_limit(next_off_w, wrap_q, size_q, limit_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            limit_q <= '0;
        end else if (accept) begin
            limit_q <= bus.SEG_LIMIT;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^bus.SEG_LIMIT;
    assign first_viol   = 1'b0;
    assign next_viol    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        wrap_d     = wrap_q;
        size_d     = size_q;
        dir_pop_d  = dir_pop_q;
        n_d        = n_q;
        base_d     = base_q;
        idx_d      = idx_q;
        addr_out_d = addr_out_q;
        final_sp_d = final_sp_q;
        addr_v_d   = addr_v_q;
        last_d     = last_q;
        done_d     = 1'b0;
        exc_d      = exc_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d    = req_size;
                    dir_pop_d = bus.DIR_POP;
                    n_d       = req_n;
                    base_d    = req_base;
                    if (req_n == '0) begin
                        done_d     = 1'b1;
                        final_sp_d = bus.SP_IN;
                    end else begin
                        offset_d   = first_off_w[ADDR_W-1:0];
                        wrap_d     = first_off_w[ADDR_W];
                        idx_d      = '0;
                        last_d     = (req_n == NB_W'(1));
                        addr_out_d = req_base + first_off_w[ADDR_W-1:0];
                        if (first_viol) begin
                            state_d  = EXC;
                            exc_d    = 1'b1;
                            addr_v_d = 1'b0;
                            last_d   = 1'b0;
                        end else begin
                            state_d  = RUN;
                            addr_v_d = 1'b1;
                        end
                    end
                end
            end

            RUN: begin
                if (bus.FLUSH) begin
                    state_d  = IDLE;
                    addr_v_d = 1'b0;
                    last_d   = 1'b0;
                    exc_d    = 1'b0;
                end else if (!bus.STALL_IN) begin
                    if (last_q) begin
                        state_d    = IDLE;
                        addr_v_d   = 1'b0;
                        last_d     = 1'b0;
                        done_d     = 1'b1;
                        // Push: SP - N*S is the last beat's offset; pop needs one more step.
                        final_sp_d = dir_pop_q ? next_off_w[ADDR_W-1:0] : offset_q;
                    end else begin
                        offset_d   = next_off_w[ADDR_W-1:0];
                        wrap_d     = wrap_q | next_off_w[ADDR_W];
                        idx_d      = idx_inc;
                        last_d     = (NB_W'(idx_inc) == n_q - NB_W'(1));
                        addr_out_d = base_q + next_off_w[ADDR_W-1:0];
                        if (next_viol) begin
                            state_d  = EXC;
                            exc_d    = 1'b1;
                            addr_v_d = 1'b0;
                            last_d   = 1'b0;
                        end
                    end
                end
            end

            EXC: begin
                if (bus.FLUSH) begin
                    state_d = IDLE;
                    exc_d   = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                addr_v_d = 1'b0;
                last_d   = 1'b0;
                exc_d    = 1'b0;
            end
        endcase

        // Ready is withheld during the DONE cycle, giving one bubble between sequences.
        rdy_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            wrap_q     <= 1'b0;
            size_q     <= 4'd2;
            dir_pop_q  <= 1'b0;
            n_q        <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            addr_out_q <= '0;
            final_sp_q <= '0;
            addr_v_q   <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            wrap_q     <= wrap_d;
            size_q     <= size_d;
            dir_pop_q  <= dir_pop_d;
            n_q        <= n_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            addr_out_q <= addr_out_d;
            final_sp_q <= final_sp_d;
            addr_v_q   <= addr_v_d;
            last_q     <= last_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            rdy_q      <= rdy_d;
        end
    end

    assign bus.START_RDY         = rdy_q;
    assign bus.ADDR_V            = addr_v_q;
    assign bus.ADDR_OUT          = addr_out_q;
    assign bus.BEAT_IDX          = idx_q;
    assign bus.LAST              = last_q;
    assign bus.DONE              = done_q;
    assign bus.FINAL_SP          = final_sp_q;
    assign bus.SEG_LIMIT_EXC_OUT = exc_q;
    assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_ag_stack_seq.sv
// Self-checking bench for ag_stack_seq; the limit scenarios are built when AG_SEQ_LIMIT_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_ag_stack_seq;
    localparam int ADDR_W    = 32;
    localparam int MAX_BEATS = 8;
    localparam int NB_W      = $clog2(MAX_BEATS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] obs_addr_q[$];
    int                obs_idx_q[$];
    logic              obs_last_q[$];
    int                obs_cyc_q[$];
    int                done_cnt = 0;
    logic [ADDR_W-1:0] done_sp = '0;

    ag_stack_seq_if #(.ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) bus ();

    ag_stack_seq #(.ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS), .SEG_SHIFT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // monitor: record retired beats and DONE pulses mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ADDR_V && !bus.STALL_IN) begin
                obs_addr_q.push_back(bus.ADDR_OUT);
                obs_idx_q.push_back(int'(bus.BEAT_IDX));
                obs_last_q.push_back(bus.LAST);
                obs_cyc_q.push_back(cyc);
            end
            if (bus.DONE) begin
                done_cnt++;
                done_sp = bus.FINAL_SP;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.START_V   = 1'b0;
        bus.DIR_POP   = 1'b0;
        bus.DATA_SIZE = 2'b00;
        bus.NUM_BEATS = '0;
        bus.SP_IN     = '0;
        bus.SEG_BASE  = '0;
        bus.SEG_LIMIT = '1;
        bus.FLUSH     = 1'b0;
        bus.STALL_IN  = 1'b0;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_addr_q.delete();
        obs_idx_q.delete();
        obs_last_q.delete();
        obs_cyc_q.delete();
        done_cnt = 0;
        done_sp  = '0;
    endtask

    task automatic drive_req(input logic pop, input logic [1:0] ds, input int n,
                             input logic [31:0] sp, input logic [15:0] seg,
                             input logic [31:0] lim);
        bus.START_V   = 1'b1;
        bus.DIR_POP   = pop;
        bus.DATA_SIZE = ds;
        bus.NUM_BEATS = NB_W'(n);
        bus.SP_IN     = sp;
        bus.SEG_BASE  = seg;
        bus.SEG_LIMIT = lim;
        step();
        bus.START_V   = 1'b0;
    endtask

    // scoreboard model: beat i offset = SP - (i+1)*S (push) or SP + i*S (pop)
    task automatic push_exp(input logic pop, input int sz, input int n,
                            input logic [31:0] sp, input logic [15:0] seg);
        logic [31:0] base;
        base = {seg, 16'h0000};
        for (int i = 0; i < n; i++) begin
            if (pop) exp_q.push_back(base + sp + 32'(i * sz));
            else     exp_q.push_back(base + sp - 32'((i + 1) * sz));
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT});
        end
        checks++;
        if (bus.ADDR_OUT !== 32'h0 || bus.FINAL_SP !== 32'h0 || bus.BEAT_IDX !== '0) begin
            errors++;
            $display("FAIL reset_values got addr=%h sp=%h idx=%0d want 0/0/0",
                     bus.ADDR_OUT, bus.FINAL_SP, bus.BEAT_IDX);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.START_RDY !== 1'b1 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b want 1/0", bus.START_RDY, bus.ADDR_V);
        end
    endtask

    task automatic test_push_burst();
        logic [31:0] a, e;
        int idx, c0, c;
        logic l;
        clear_obs();
        push_exp(1'b0, 4, 8, 32'h0000_1000, 16'h0010);
        drive_req(1'b0, 2'b10, 8, 32'h0000_1000, 16'h0010, '1);
        checks++;
        if (bus.ADDR_V !== 1'b1 || bus.ADDR_OUT !== 32'h0010_0FFC) begin
            errors++;
            $display("FAIL push_latency got v=%b addr=%h want 1/00100ffc", bus.ADDR_V, bus.ADDR_OUT);
        end
        repeat (10) step();
        checks++;
        if (obs_addr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL push_count got %0d want %0d", obs_addr_q.size(), exp_q.size());
        end
        c0 = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : 0;
        for (int i = 0; i < 8 && obs_addr_q.size() > 0 && exp_q.size() > 0; i++) begin
            a = obs_addr_q.pop_front();
            e = exp_q.pop_front();
            idx = obs_idx_q.pop_front();
            l = obs_last_q.pop_front();
            c = obs_cyc_q.pop_front();
            checks++;
            if (a !== e || idx != i || l !== (i == 7) || c != c0 + i) begin
                errors++;
                $display("FAIL push_beat%0d got addr=%h idx=%0d last=%b cyc=+%0d want %h/%0d/%b/+%0d",
                         i, a, idx, l, c - c0, e, i, (i == 7), i);
            end
        end
        checks++;
        if (done_cnt != 1 || done_sp !== 32'h0000_0FE0) begin
            errors++;
            $display("FAIL push_done got cnt=%0d sp=%h want 1/00000fe0", done_cnt, done_sp);
        end
    endtask

    task automatic test_pop_wrap();
        logic [31:0] a, e;
        clear_obs();
`ifdef AG_SEQ_LIMIT_CHECK_EN
        push_exp(1'b1, 2, 1, 32'hFFFF_FFFE, 16'h0000);
`else
        push_exp(1'b1, 2, 2, 32'hFFFF_FFFE, 16'h0000);
`endif
        drive_req(1'b1, 2'b01, 2, 32'hFFFF_FFFE, 16'h0000, 32'hFFFF_FFFF);
        repeat (5) step();
        checks++;
        if (obs_addr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pop_count got %0d want %0d", obs_addr_q.size(), exp_q.size());
        end
        while (obs_addr_q.size() > 0 && exp_q.size() > 0) begin
            a = obs_addr_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pop_addr got %h want %h", a, e);
            end
        end
`ifdef AG_SEQ_LIMIT_CHECK_EN
        checks++;
        if (bus.SEG_LIMIT_EXC_OUT !== 1'b1 || done_cnt != 0 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL pop_wrap_exc got exc=%b done=%0d v=%b want 1/0/0",
                     bus.SEG_LIMIT_EXC_OUT, done_cnt, bus.ADDR_V);
        end
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        checks++;
        if (bus.SEG_LIMIT_EXC_OUT !== 1'b0 || bus.START_RDY !== 1'b1) begin
            errors++;
            $display("FAIL pop_wrap_flush got exc=%b rdy=%b want 0/1", bus.SEG_LIMIT_EXC_OUT, bus.START_RDY);
        end
`else
        checks++;
        if (done_cnt != 1 || done_sp !== 32'h0000_0002) begin
            errors++;
            $display("FAIL pop_done got cnt=%0d sp=%h want 1/00000002", done_cnt, done_sp);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] a, e;
        clear_obs();
        push_exp(1'b0, 8, 2, 32'h0000_2000, 16'h0000);
        drive_req(1'b0, 2'b11, 2, 32'h0000_2000, 16'h0000, '1);
        for (int k = 0; k < 4; k++) begin
            bus.STALL_IN = (k < 3);
            checks++;
            if (bus.ADDR_V !== 1'b1 || bus.ADDR_OUT !== 32'h0000_1FF8 || bus.BEAT_IDX !== '0) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b addr=%h idx=%0d want 1/00001ff8/0",
                         k, bus.ADDR_V, bus.ADDR_OUT, bus.BEAT_IDX);
            end
            step();
        end
        bus.STALL_IN = 1'b0;
        checks++;
        if (bus.ADDR_OUT !== 32'h0000_1FF0 || bus.BEAT_IDX !== 3'd1 || bus.LAST !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat1 got addr=%h idx=%0d last=%b want 00001ff0/1/1",
                     bus.ADDR_OUT, bus.BEAT_IDX, bus.LAST);
        end
        repeat (3) step();
        checks++;
        if (obs_addr_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count got %0d want 2", obs_addr_q.size());
        end
        while (obs_addr_q.size() > 0 && exp_q.size() > 0) begin
            a = obs_addr_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stall_addr got %h want %h", a, e);
            end
        end
        checks++;
        if (done_cnt != 1 || done_sp !== 32'h0000_1FF0) begin
            errors++;
            $display("FAIL stall_done got cnt=%0d sp=%h want 1/00001ff0", done_cnt, done_sp);
        end
    endtask

    task automatic test_flush();
        clear_obs();
        drive_req(1'b0, 2'b10, 8, 32'h0000_1000, 16'h0000, '1);
        repeat (3) step();
        checks++;
        if (bus.BEAT_IDX !== 3'd3 || bus.ADDR_V !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got idx=%0d v=%b want 3/1", bus.BEAT_IDX, bus.ADDR_V);
        end
        bus.FLUSH     = 1'b1;
        bus.START_V   = 1'b1;
        bus.NUM_BEATS = NB_W'(1);
        bus.SP_IN     = 32'h0000_0500;
        step();
        bus.FLUSH   = 1'b0;
        bus.START_V = 1'b0;
        checks++;
        if (bus.ADDR_V !== 1'b0 || bus.START_RDY !== 1'b1 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got v=%b rdy=%b done=%b want 0/1/0", bus.ADDR_V, bus.START_RDY, bus.DONE);
        end
        repeat (5) step();
        checks++;
        if (done_cnt != 0 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done got cnt=%0d v=%b want 0/0", done_cnt, bus.ADDR_V);
        end
        // FLUSH beside a request while idle must also drop the request
        bus.FLUSH     = 1'b1;
        bus.START_V   = 1'b1;
        bus.NUM_BEATS = '0;
        bus.SP_IN     = 32'h0000_0077;
        step();
        bus.FLUSH   = 1'b0;
        bus.START_V = 1'b0;
        checks++;
        if (bus.DONE !== 1'b0 || bus.START_RDY !== 1'b1 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins got done=%b rdy=%b v=%b want 0/1/0", bus.DONE, bus.START_RDY, bus.ADDR_V);
        end
    endtask

    task automatic test_zero_beats();
        clear_obs();
        drive_req(1'b0, 2'b10, 0, 32'h0000_1234, 16'h0000, '1);
        checks++;
        if (bus.DONE !== 1'b1 || bus.FINAL_SP !== 32'h0000_1234 || bus.ADDR_V !== 1'b0 || bus.START_RDY !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b sp=%h v=%b rdy=%b want 1/00001234/0/0",
                     bus.DONE, bus.FINAL_SP, bus.ADDR_V, bus.START_RDY);
        end
        step();
        checks++;
        if (bus.DONE !== 1'b0 || bus.START_RDY !== 1'b1 || obs_addr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_after got done=%b rdy=%b beats=%0d want 0/1/0",
                     bus.DONE, bus.START_RDY, obs_addr_q.size());
        end
    endtask

    task automatic test_clamp();
        logic [31:0] a, e;
        clear_obs();
        push_exp(1'b0, 2, 8, 32'h0000_0100, 16'h0000);
        drive_req(1'b0, 2'b00, 12, 32'h0000_0100, 16'h0000, '1);
        repeat (12) step();
        checks++;
        if (obs_addr_q.size() != 8) begin
            errors++;
            $display("FAIL clamp_count got %0d want 8", obs_addr_q.size());
        end
        while (obs_addr_q.size() > 0 && exp_q.size() > 0) begin
            a = obs_addr_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL clamp_addr got %h want %h", a, e);
            end
        end
        checks++;
        if (done_cnt != 1 || done_sp !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL clamp_done got cnt=%0d sp=%h want 1/000000f0", done_cnt, done_sp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, e;
        clear_obs();
        push_exp(1'b1, 4, 3, 32'h0000_0040, 16'h0001);
        drive_req(1'b1, 2'b10, 3, 32'h0000_0040, 16'h0001, '1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.ADDR_V !== 1'b1 || bus.START_RDY !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run%0d got v=%b rdy=%b want 1/0", k, bus.ADDR_V, bus.START_RDY);
            end
            step();
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.START_RDY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle got done=%b rdy=%b want 1/0", bus.DONE, bus.START_RDY);
        end
        push_exp(1'b0, 8, 1, 32'h0000_0080, 16'h0001);
        bus.START_V   = 1'b1;
        bus.DIR_POP   = 1'b0;
        bus.DATA_SIZE = 2'b11;
        bus.NUM_BEATS = NB_W'(1);
        bus.SP_IN     = 32'h0000_0080;
        bus.SEG_BASE  = 16'h0001;
        step();
        checks++;
        if (bus.START_RDY !== 1'b1 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble got rdy=%b v=%b want 1/0", bus.START_RDY, bus.ADDR_V);
        end
        step();
        bus.START_V = 1'b0;
        checks++;
        if (bus.ADDR_V !== 1'b1 || bus.ADDR_OUT !== 32'h0001_0078) begin
            errors++;
            $display("FAIL b2b_second got v=%b addr=%h want 1/00010078", bus.ADDR_V, bus.ADDR_OUT);
        end
        repeat (4) step();
        checks++;
        if (obs_addr_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", obs_addr_q.size());
        end
        while (obs_addr_q.size() > 0 && exp_q.size() > 0) begin
            a = obs_addr_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL b2b_addr got %h want %h", a, e);
            end
        end
        checks++;
        if (done_cnt != 2 || done_sp !== 32'h0000_0078) begin
            errors++;
            $display("FAIL b2b_done got cnt=%0d sp=%h want 2/00000078", done_cnt, done_sp);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        drive_req(1'b0, 2'b10, 8, 32'h0000_1000, 16'h0000, '1);
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT} !== 5'b10000 ||
            bus.ADDR_OUT !== 32'h0 || bus.FINAL_SP !== 32'h0 || bus.BEAT_IDX !== '0) begin
            errors++;
            $display("FAIL reset_mid got flags=%b addr=%h sp=%h idx=%0d want 10000/0/0/0",
                     {bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT},
                     bus.ADDR_OUT, bus.FINAL_SP, bus.BEAT_IDX);
        end
        rst = 1'b0;
        clear_obs();
        repeat (10) step();
        checks++;
        if (done_cnt != 0 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet got done=%0d v=%b want 0/0", done_cnt, bus.ADDR_V);
        end
    endtask

`ifdef AG_SEQ_LIMIT_CHECK_EN
    task automatic test_limit_exc();
        logic any_v;
        clear_obs();
        drive_req(1'b0, 2'b10, 2, 32'h0000_0010, 16'h0000, 32'h0000_000B);
        any_v = bus.ADDR_V;
        checks++;
        if (bus.SEG_LIMIT_EXC_OUT !== 1'b1 || bus.ADDR_V !== 1'b0) begin
            errors++;
            $display("FAIL limit_enter got exc=%b v=%b want 1/0", bus.SEG_LIMIT_EXC_OUT, bus.ADDR_V);
        end
        for (int k = 0; k < 4; k++) begin
            bus.STALL_IN = k[0];
            step();
            any_v = any_v | bus.ADDR_V;
        end
        bus.STALL_IN = 1'b0;
        checks++;
        if (bus.SEG_LIMIT_EXC_OUT !== 1'b1 || any_v !== 1'b0 || done_cnt != 0 || bus.START_RDY !== 1'b0) begin
            errors++;
            $display("FAIL limit_hold got exc=%b any_v=%b done=%0d rdy=%b want 1/0/0/0",
                     bus.SEG_LIMIT_EXC_OUT, any_v, done_cnt, bus.START_RDY);
        end
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        checks++;
        if (bus.SEG_LIMIT_EXC_OUT !== 1'b0 || bus.START_RDY !== 1'b1) begin
            errors++;
            $display("FAIL limit_flush got exc=%b rdy=%b want 0/1", bus.SEG_LIMIT_EXC_OUT, bus.START_RDY);
        end
        drive_req(1'b0, 2'b10, 2, 32'h0000_0010, 16'h0000, 32'h0000_000B);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT} !== 5'b10000 ||
            bus.ADDR_OUT !== 32'h0 || bus.FINAL_SP !== 32'h0) begin
            errors++;
            $display("FAIL limit_reset got flags=%b addr=%h sp=%h want 10000/0/0",
                     {bus.START_RDY, bus.ADDR_V, bus.LAST, bus.DONE, bus.SEG_LIMIT_EXC_OUT},
                     bus.ADDR_OUT, bus.FINAL_SP);
        end
        step();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_push_burst();
        test_pop_wrap();
        test_stall();
        test_flush();
        test_zero_beats();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
`ifdef AG_SEQ_LIMIT_CHECK_EN
        test_limit_exc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ag_stack_seq.md
Name: ag_stack_seq

Overview:
- Parametrised successor to the single-shot AG-stage stack address path.
- Sequences multi-beat stack accesses: PUSHA/POPA, far CALL/RET (CS+EIP), ENTER frames, and 64-bit MM pushes.
- Emits one segmented linear address per beat, plus the final SP. Optionally checks every beat against the segment limit.
- Sits between the decode/AG latches and the ME stage. It is the only source of stack addresses for multi-beat ops.

Parameters:
- ADDR_W, 32, width of offsets, SP and linear addresses.
- MAX_BEATS, 8, maximum beats per sequence; NUM_BEATS width is clog2(MAX_BEATS+1).
- SEG_SHIFT, 16, left shift applied to SEG_BASE to form the segment base.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- START_V  in  1  request valid.
- START_RDY  out  1  sequencer can accept a request (high only in IDLE).
- DIR_POP  in  1  0 = push (pre-decrement), 1 = pop (post-increment).
- DATA_SIZE  in  2  beat size: 00/01 = 2 B, 10 = 4 B, 11 = 8 B.
- NUM_BEATS  in  clog2(MAX_BEATS+1)  beats requested.
- SP_IN  in  ADDR_W  starting stack pointer.
- SEG_BASE  in  16  SS selector base.
- SEG_LIMIT  in  ADDR_W  SS limit (offset of last valid byte).
- FLUSH  in  1  abort the current sequence.
- STALL_IN  in  1  ME not ready; hold the current beat.
- ADDR_V  out  1  beat address valid.
- ADDR_OUT  out  ADDR_W  linear address = (SEG_BASE << SEG_SHIFT) + offset, modulo 2^ADDR_W.
- BEAT_IDX  out  clog2(MAX_BEATS)  index of the current beat.
- LAST  out  1  current beat is the final one.
- DONE  out  1  one-cycle pulse when the sequence completes.
- FINAL_SP  out  ADDR_W  SP after the sequence; valid when DONE.
- SEG_LIMIT_EXC_OUT  out  1  limit violation; held until FLUSH or RST.

Behaviour:
- Reset (RST high at a CLK edge): state = IDLE.
  - START_RDY = 1.
  - ADDR_V, LAST, DONE, SEG_LIMIT_EXC_OUT = 0.
  - ADDR_OUT, FINAL_SP, BEAT_IDX = 0.
  - Reset mid-sequence discards everything; no DONE is produced.
- States: IDLE, RUN, EXC.
  - IDLE -> RUN on START_V & START_RDY & !FLUSH. Latch SP_IN, size, DIR_POP, NUM_BEATS, SEG_BASE, SEG_LIMIT.
  - NUM_BEATS = 0: stay in IDLE and pulse DONE the next cycle with FINAL_SP = SP_IN. No ADDR_V.
  - NUM_BEATS > MAX_BEATS: clamp to MAX_BEATS.
- Latency: request accepted at edge T -> first ADDR_V during cycle T+1. All outputs are registered.
- Beat i offset, with size S:
  - push: SP - (i+1)*S.
  - pop: SP + i*S.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is legal, with no carry out.
- RUN:
  - ADDR_V = 1.
  - STALL_IN = 1 holds ADDR_OUT, BEAT_IDX and LAST stable.
  - A beat retires on a cycle with ADDR_V & !STALL_IN.
  - Retiring the LAST beat -> IDLE, DONE pulses the same cycle with:
    - push: FINAL_SP = SP - N*S.
    - pop: FINAL_SP = SP + N*S.
  - START_RDY returns high the cycle after DONE. Back-to-back sequences therefore have one idle bubble.
- FLUSH:
  - Any state: next state is IDLE; ADDR_V and SEG_LIMIT_EXC_OUT cleared; no DONE.
  - FLUSH with START_V in the same cycle: FLUSH wins and the request is not accepted.
  - RST takes priority over FLUSH.
- STALL_IN during IDLE or EXC: ignored.

Optional Feature:
- Macro AG_SEQ_LIMIT_CHECK_EN.
- Defined:
  - Each beat is checked before presentation: violation if offset + S - 1 > SEG_LIMIT, using ADDR_W+1-bit compare so wrap counts as a violation.
  - On violation: that beat is not presented (ADDR_V = 0). Go to EXC, assert SEG_LIMIT_EXC_OUT, no DONE.
  - EXC is left only by FLUSH or RST.
- Not defined: SEG_LIMIT_EXC_OUT tied 0, EXC is unreachable, SEG_LIMIT is unused.

Test Plan:
- Push, 4 B, NUM_BEATS=8, SP_IN=0x0000_1000, SEG_BASE=0x0010, no stall -> ADDR_OUT 0x0010_0FFC, 0x0010_0FF8 ... 0x0010_0FE0 on 8 consecutive cycles starting T+1.
  - LAST on beat 7, DONE with FINAL_SP=0x0000_0FE0.
- Pop, 2 B, NUM_BEATS=2, SP_IN=0xFFFF_FFFE, SEG_BASE=0 -> offsets 0xFFFF_FFFE then 0x0000_0000 (wrap).
  - FINAL_SP=0x0000_0002.
  - With AG_SEQ_LIMIT_CHECK_EN and SEG_LIMIT=0xFFFF_FFFF, beat 1 raises SEG_LIMIT_EXC_OUT.
- Push, 8 B, NUM_BEATS=2, STALL_IN high for 3 cycles on beat 0 -> ADDR_OUT holds 0x…FF8 for 4 cycles.
  - Beat 1 = …FF0 next; DONE exactly once.
- FLUSH asserted during beat 3 of 8, with START_V high in the same cycle -> IDLE next cycle, no DONE, request not accepted.
  - START_RDY = 1 the following cycle.
- NUM_BEATS=0, SP_IN=0x1234 -> no ADDR_V, DONE pulse at T+1 with FINAL_SP=0x1234.
- With AG_SEQ_LIMIT_CHECK_EN: push, 4 B, SP_IN=0x10, SEG_LIMIT=0x0B, N=2 -> beat 0 (0x0C, needs 0x0C–0x0F > 0x0B) faults.
  - ADDR_V never asserted, SEG_LIMIT_EXC_OUT held until FLUSH.
  - RST mid-EXC clears all outputs.
